vga_timing_gen: RTL and testbench

//  Raster timing generator for the VGA/LCD output path; sits directly upstream of the pixel colour generator.

---
 rtl/vga_timing_gen_pkg.sv | 41 ++++
 rtl/vga_hv_counter.sv | 48 ++++
 rtl/vga_timing_gen.sv | 111 +++++++++++
 tb/tb_vga_timing_gen.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared types and timing presets for the VGA/LCD raster timing generator.
package vga_timing_gen_pkg;

  localparam int unsigned CntW = 11;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } state_e;

  typedef struct packed {
    logic [CntW-1:0] h_sync;
    logic [CntW-1:0] h_back;
    logic [CntW-1:0] h_disp;
    logic [CntW-1:0] h_front;
    logic [CntW-1:0] v_sync;
    logic [CntW-1:0] v_back;
    logic [CntW-1:0] v_disp;
    logic [CntW-1:0] v_front;
  } timing_t;

  localparam timing_t Timing640x480 = '{
    h_sync: 11'd96,  h_back: 11'd48,  h_disp: 11'd640,  h_front: 11'd16,
    v_sync: 11'd2,   v_back: 11'd33,  v_disp: 11'd480,  v_front: 11'd10
  };
  localparam timing_t Timing800x600 = '{
    h_sync: 11'd128, h_back: 11'd88,  h_disp: 11'd800,  h_front: 11'd40,
    v_sync: 11'd4,   v_back: 11'd23,  v_disp: 11'd600,  v_front: 11'd1
  };
  localparam timing_t Timing1024x768 = '{
    h_sync: 11'd136, h_back: 11'd160, h_disp: 11'd1024, h_front: 11'd24,
    v_sync: 11'd6,   v_back: 11'd29,  v_disp: 11'd768,  v_front: 11'd3
  };

  function automatic int unsigned axis_total(int unsigned sync, int unsigned back,
                                             int unsigned disp, int unsigned front);
    return sync + back + disp + front;
  endfunction

endpackage

// File: rtl/vga_hv_counter.sv
// Horizontal/vertical raster counters with synchronous clear and wrap flags.
module vga_hv_counter
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned HTotal = 1056,
  parameter int unsigned VTotal = 628
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  output logic [CntW-1:0] h_cnt_o,
  output logic [CntW-1:0] v_cnt_o,
  output logic            line_end_o,
  output logic            frame_end_o
);

  logic [CntW-1:0] h_cnt_d, h_cnt_q;
  logic [CntW-1:0] v_cnt_d, v_cnt_q;

  assign line_end_o  = (h_cnt_q == CntW'(HTotal - 1));
  assign frame_end_o = line_end_o && (v_cnt_q == CntW'(VTotal - 1));

  always_comb begin
    h_cnt_d = h_cnt_q + CntW'(1);
    v_cnt_d = v_cnt_q;
    if (clr_i) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (line_end_o) begin
      h_cnt_d = '0;
      v_cnt_d = frame_end_o ? '0 : v_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt_o = h_cnt_q;
  assign v_cnt_o = v_cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: enable FSM, active-window decode and registered panel outputs.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned H_SYNC  = 128,
  parameter int unsigned H_BACK  = 88,
  parameter int unsigned H_DISP  = 800,
  parameter int unsigned H_FRONT = 40,
  parameter int unsigned V_SYNC  = 4,
  parameter int unsigned V_BACK  = 23,
  parameter int unsigned V_DISP  = 600,
  parameter int unsigned V_FRONT = 1,
  parameter logic        HS_POL  = 1'b0,
  parameter logic        VS_POL  = 1'b0
) (
  input  logic        lcd_pclk,
  input  logic        rst,
  input  logic        disp_en,
  input  logic [15:0] pixel_data,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic [10:0] h_disp,
  output logic [10:0] v_disp,
  output logic        data_req,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic [15:0] lcd_rgb,
  output logic        frame_start,
  output logic        busy
);

  localparam int unsigned HB     = H_SYNC + H_BACK;
  localparam int unsigned VB     = V_SYNC + V_BACK;
  localparam int unsigned HTotal = axis_total(H_SYNC, H_BACK, H_DISP, H_FRONT);
  localparam int unsigned VTotal = axis_total(V_SYNC, V_BACK, V_DISP, V_FRONT);

  if (HTotal > 2047 || VTotal > 2047) begin : g_total_too_big
    $error("vga_timing_gen: H or V total exceeds 11-bit counter range");
  end

  state_e          state_d, state_q;
  logic [CntW-1:0] h_cnt, v_cnt;
  logic            unused_line_end;
  logic            frame_end;
  logic            hs_d, hs_q, vs_d, vs_q, de_q;

  vga_hv_counter #(
    .HTotal (HTotal),
    .VTotal (VTotal)
  ) u_hv_counter (
    .clk_i       (lcd_pclk),
    .rst_i       (rst),
    .clr_i       (state_q == StIdle),
    .h_cnt_o     (h_cnt),
    .v_cnt_o     (v_cnt),
    .line_end_o  (unused_line_end),
    .frame_end_o (frame_end)
  );

  // Stopping is only allowed on the last cycle of a frame, so output never truncates mid-frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (disp_en) state_d = StRun;
      StRun:   if (!disp_en) state_d = frame_end ? StIdle : StDrain;
      StDrain: begin
        if (disp_en)        state_d = StRun;
        else if (frame_end) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy     = (state_q != StIdle);
  assign data_req = busy
                 && (h_cnt >= CntW'(HB)) && (h_cnt < CntW'(HB + H_DISP))
                 && (v_cnt >= CntW'(VB)) && (v_cnt < CntW'(VB + V_DISP));

  assign pixel_xpos  = data_req ? h_cnt - CntW'(HB) : '0;
  assign pixel_ypos  = data_req ? v_cnt - CntW'(VB) : '0;
  assign h_disp      = CntW'(H_DISP);
  assign v_disp      = CntW'(V_DISP);
  assign frame_start = (state_q == StRun) && (h_cnt == '0) && (v_cnt == '0);

  // Syncs/DE lag the counters by one cycle to line up with the colour generator's register.
  always_comb begin
    hs_d = (busy && (h_cnt < CntW'(H_SYNC))) ? HS_POL : ~HS_POL;
    vs_d = (busy && (v_cnt < CntW'(V_SYNC))) ? VS_POL : ~VS_POL;
  end

  always_ff @(posedge lcd_pclk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      de_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= data_req;
    end
  end

  assign lcd_hs  = hs_q;
  assign lcd_vs  = vs_q;
  assign lcd_de  = de_q;
  assign lcd_rgb = de_q ? pixel_data : 16'h0000;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small raster, frame-position model, two polarity variants.
module tb_vga_timing_gen;

  localparam int HT = 14;  // 2 sync + 2 back + 8 disp + 2 front
  localparam int VT = 7;   // 1 sync + 1 back + 4 disp + 1 front
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst;
  logic        disp_en = 1'b0;
  logic [15:0] pd0, pd1, rgb0, rgb1;
  logic [10:0] x0, y0, x1, y1, hd0, vd0, hd1, vd1;
  logic        dr0, dr1, hs0, hs1, vs0, vs1, de0, de1, fs0, fs1, bz0, bz1;

  int vectors = 0;
  int miscompares = 0;

  // Model: running flag plus linear position inside the 98-cycle frame.
  bit          m_run = 1'b0;
  int          m_pos = 0;
  bit          m_hs_act = 1'b0, m_vs_act = 1'b0, m_de_r = 1'b0;
  logic [15:0] m_rgb_r = '0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_SYNC(2), .H_BACK(2), .H_DISP(8), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) u_dut0 (
    .lcd_pclk(clk), .rst(rst), .disp_en(disp_en), .pixel_data(pd0),
    .pixel_xpos(x0), .pixel_ypos(y0), .h_disp(hd0), .v_disp(vd0), .data_req(dr0),
    .lcd_hs(hs0), .lcd_vs(vs0), .lcd_de(de0), .lcd_rgb(rgb0), .frame_start(fs0), .busy(bz0)
  );

  vga_timing_gen #(
    .H_SYNC(2), .H_BACK(2), .H_DISP(8), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_dut1 (
    .lcd_pclk(clk), .rst(rst), .disp_en(disp_en), .pixel_data(pd1),
    .pixel_xpos(x1), .pixel_ypos(y1), .h_disp(hd1), .v_disp(vd1), .data_req(dr1),
    .lcd_hs(hs1), .lcd_vs(vs1), .lcd_de(de1), .lcd_rgb(rgb1), .frame_start(fs1), .busy(bz1)
  );

  // Colour generators: registered coordinate echo, garbage outside the active window.
  always @(posedge clk) begin
    pd0 <= dr0 ? {5'd0, y0[4:0], x0[5:0]} : 16'($urandom);
    pd1 <= dr1 ? {5'd0, y1[4:0], x1[5:0]} : 16'($urandom);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk or posedge rst) begin : model_adv
    int h, v;
    bit act;
    if (rst) begin
      m_run = 1'b0; m_pos = 0;
      m_hs_act = 1'b0; m_vs_act = 1'b0; m_de_r = 1'b0; m_rgb_r = '0;
    end else begin
      h = m_pos % HT;
      v = m_pos / HT;
      act = m_run && h >= 4 && h < 12 && v >= 2 && v < 6;
      m_hs_act = m_run && h < 2;
      m_vs_act = m_run && v < 1;
      m_de_r   = act;
      m_rgb_r  = {5'd0, 5'(v - 2), 6'(h - 4)};
      if (m_run) begin
        if (!disp_en && m_pos == FT - 1) begin
          m_run = 1'b0;
          m_pos = 0;
        end else begin
          m_pos = (m_pos + 1) % FT;
        end
      end else if (disp_en) begin
        m_run = 1'b1;
        m_pos = 0;
      end
    end
  end

  always @(negedge clk) begin : compare
    int h, v, x, y;
    bit act;
    h = m_pos % HT;
    v = m_pos / HT;
    act = m_run && h >= 4 && h < 12 && v >= 2 && v < 6;
    x = act ? h - 4 : 0;
    y = act ? v - 2 : 0;
    check("data_req0", dr0, act);          check("data_req1", dr1, act);
    check("xpos0", x0, x);                 check("xpos1", x1, x);
    check("ypos0", y0, y);                 check("ypos1", y1, y);
    check("busy0", bz0, m_run);            check("busy1", bz1, m_run);
    check("frame_start0", fs0, m_run && m_pos == 0);
    check("frame_start1", fs1, m_run && m_pos == 0);
    check("hs0", hs0, !m_hs_act);          check("hs1", hs1, m_hs_act);
    check("vs0", vs0, !m_vs_act);          check("vs1", vs1, m_vs_act);
    check("de0", de0, m_de_r);             check("de1", de1, m_de_r);
    check("rgb0", rgb0, m_de_r ? m_rgb_r : 16'h0);
    check("rgb1", rgb1, m_de_r ? m_rgb_r : 16'h0);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int first_req, de_cnt, next_fs, n, sync_seen, hold;
    rst = 1'b1;
    step(); step();
    check("hdisp0", hd0, 8);   check("vdisp0", vd0, 4);
    check("hdisp1", hd1, 8);   check("vdisp1", vd1, 4);
    check("rst_hs0", hs0, 1);  check("rst_hs1", hs1, 0);
    check("rst_busy", bz0, 0); check("rst_rgb", rgb0, 0);

    // Start from reset with disp_en high.
    disp_en = 1'b1;
    rst = 1'b0;
    step();
    check("fs_cycle0", fs0, 1);
    first_req = -1; de_cnt = 0; next_fs = -1;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (k == 1) check("hs_active_c1", hs0, 0);
      if (k == 3) check("hs_idle_c3", hs0, 1);
      if (dr0 && first_req < 0) begin
        first_req = k;
        check("first_xpos", x0, 0);
        check("first_ypos", y0, 0);
      end
      if (de0 && k <= 98) de_cnt++;
      if (fs0 && next_fs < 0) next_fs = k;
    end
    check("first_req_cycle", first_req, 32);
    check("de_per_frame", de_cnt, 32);
    check("frame_period", next_fs, 98);

    // Drop disp_en at h=5,v=3: frame must complete, then go quiet.
    for (int k = 0; k < 200 && m_pos != 3 * HT + 5; k++) step();
    disp_en = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (bz0 && n < 300);
    check("drain_len", n, 51);
    sync_seen = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (!hs0 || !vs0 || de0) sync_seen++;
    end
    check("quiet_after_drain", sync_seen, 0);

    // Re-assert during DRAIN: counters undisturbed, next frame_start 98 cycles later.
    disp_en = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!fs0 && n < 300);
    check("restart_fs", fs0, 1);
    n = 0;
    do begin
      step();
      n++;
      if (m_pos == 20) disp_en = 1'b0;
      if (m_pos == 60) disp_en = 1'b1;
    end while (!fs0 && n < 300);
    check("drain_reenable_period", n, 98);

    // Reset in the middle of an active line.
    for (int k = 0; k < 200 && m_pos != 3 * HT + 7; k++) step();
    check("pre_rst_de", de0, 1);
    rst = 1'b1;
    #1;
    check("midrst_busy", bz0, 0);   check("midrst_req", dr0, 0);
    check("midrst_de", de0, 0);     check("midrst_rgb", rgb0, 0);
    check("midrst_hs0", hs0, 1);    check("midrst_vs0", vs0, 1);
    check("midrst_hs1", hs1, 0);    check("midrst_xpos", x0, 0);
    step(); step();
    rst = 1'b0;
    step();
    check("post_rst_fs", fs0, 1);

    // Randomized enable pattern with occasional reset pulses.
    for (int s = 0; s < 24; s++) begin
      disp_en = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 150);
      for (int k = 0; k < hold; k++) begin
        step();
        if ($urandom_range(0, 199) == 0) begin
          rst = 1'b1;
          step();
          rst = 1'b0;
        end
      end
    end
    disp_en = 1'b0;
    for (int k = 0; k < 120; k++) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
